// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor: widths, fetch FSM encoding and
// the opcode field position that the fetch stage and the IR agree on.
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 10;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_VALID = 2'd2
  } fetch_state_e;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: asynchronous reset to RESET_PC, a jump load
// that always beats the post-fetch increment, wrapping modulo 2^ADDR_W.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // next PC: jump target, incremented PC, or hold
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads one word per request over a
// req/ack handshake and strobes it to the IR. FETCH_TIMEOUT_EN adds a sticky ack timeout.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               fetch_en,
  input  logic               jmp,
  input  logic [ADDR_W-1:0]  jmp_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_vld,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               err
);

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] instr_d;
  logic               capture_s;
  logic [ADDR_W-1:0]  pc_s;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        err_q;
  logic        err_d;
`endif

  // next state; a jump in REQ aborts the fetch even if ack arrives together
  always_comb begin
    state_d   = state_q;
    capture_s = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      FETCH_IDLE: begin
        if (fetch_en) state_d = FETCH_REQ;
        else          state_d = FETCH_IDLE;
      end
      FETCH_REQ: begin
        if (jmp) begin
          state_d = FETCH_IDLE;
        end else if (mem_ack) begin
          capture_s = 1'b1;
          state_d   = FETCH_VALID;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = FETCH_IDLE;
          end else begin
            cnt_d   = cnt_q + 16'd1;
            state_d = FETCH_REQ;
          end
`else
          state_d = FETCH_REQ;
`endif
        end
      end
      FETCH_VALID: begin
        if (fetch_en) state_d = FETCH_REQ;
        else          state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if ((state_d == FETCH_REQ) && (state_q != FETCH_REQ)) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_d;
    end
`endif
  end

  // instruction word holds until the next successful capture
  always_comb begin
    if (capture_s) instr_d = mem_rdata;
    else           instr_d = instr_q;
  end

  // state and instruction registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= FETCH_IDLE;
      instr_q <= {INSTR_W{1'b0}};
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // timeout counter and sticky error flag
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_b      (rst_b),
    .load_i     (jmp),
    .load_val_i (jmp_addr),
    .inc_i      (capture_s),
    .pc_o       (pc_s)
  );

  assign pc        = pc_s;
  assign mem_addr  = pc_s;
  assign mem_rd    = (state_q == FETCH_REQ);
  assign busy      = (state_q == FETCH_REQ);
  assign instr_vld = (state_q == FETCH_VALID);
  assign instr     = instr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic
// compared against a transaction-level fetch model.
module tb_instr_fetch;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_b;
  logic        fetch_en;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] instr;
  logic        instr_vld;
  logic [15:0] pc;
  logic        busy;
  logic        err;
  logic        ack_en;

  logic [15:0] mem [0:65535];

  int checks;
  int errors;

  int          m_pc;
  logic [15:0] m_instr;
  bit          m_fetch;
  bit          m_vld;
  bit          m_err;
  int          m_cnt;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .fetch_en  (fetch_en),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .instr     (instr),
    .instr_vld (instr_vld),
    .pc        (pc),
    .busy      (busy),
    .err       (err)
  );

  // zero-wait memory, acknowledging combinationally when ack_en allows
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_rd & ack_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 16'h0000; m_fetch = 0; m_vld = 0; m_err = 0; m_cnt = 0;
  endtask

  // one clock of fetch behaviour, described per transaction
  task automatic model_update(input bit fe, input bit j, input logic [15:0] ja, input bit ae);
    m_vld = 0;
    if (m_fetch) begin
      if (j) begin
        m_pc = ja; m_fetch = 0;
      end else if (ae) begin
        m_instr = mem[m_pc];
        m_pc    = (m_pc + 1) % 65536;
        m_vld   = 1;
        m_fetch = 0;
      end else begin
        m_cnt++;
`ifdef FETCH_TIMEOUT_EN
        if (m_cnt >= TMO) begin
          m_err = 1; m_fetch = 0;
        end
`endif
      end
    end else begin
      if (j) m_pc = ja;
      if (fe) begin
        m_fetch = 1; m_cnt = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("pc", 32'(pc), 32'(m_pc));
    check_eq("mem_rd", 32'(mem_rd), 32'(m_fetch));
    check_eq("busy", 32'(busy), 32'(m_fetch));
    check_eq("instr_vld", 32'(instr_vld), 32'(m_vld));
    check_eq("instr", 32'(instr), 32'(m_instr));
    check_eq("err", 32'(err), 32'(m_err));
    if (m_fetch) check_eq("mem_addr", 32'(mem_addr), 32'(m_pc));
  endtask

  task automatic step(input bit fe, input bit j, input logic [15:0] ja, input bit ae);
    fetch_en = fe; jmp = j; jmp_addr = ja; ack_en = ae;
    @(posedge clk);
    #1;
    model_update(fe, j, ja, ae);
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] saved;
    logic [15:0] got_q[$];
    int          idx_q[$];
    bit          fe_r, j_r, ae_r;
    logic [15:0] ja_r;

    checks = 0; errors = 0;
    rst_b = 1'b0; fetch_en = 1'b0; jmp = 1'b0; jmp_addr = 16'h0000; ack_en = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[0] = 16'hA123;
    mem[16'hFFFF] = 16'hBEEF;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_instr", 32'(instr), 32'h0);
    check_eq("rst_vld", 32'(instr_vld), 32'h0);
    check_eq("rst_mem_rd", 32'(mem_rd), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    rst_b = 1'b1;

    // single fetch, zero-wait ack: valid two cycles after the request
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    check_eq("t1_req", 32'(mem_rd), 32'h1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("t1_vld", 32'(instr_vld), 32'h1);
    check_eq("t1_instr", 32'(instr), 32'hA123);
    check_eq("t1_pc", 32'(pc), 32'h1);

    // back-to-back fetches from address 0
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    for (int s = 1; s <= 8; s++) begin
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      if (instr_vld) begin
        got_q.push_back(instr);
        idx_q.push_back(s);
      end
    end
    check_eq("t2_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check_eq("t2_word", 32'(got_q[k]), 32'(16'h1111 * (k + 1)));
        check_eq("t2_spacing", 32'(idx_q[k]), 32'(2 * k + 2));
      end
    end
    check_eq("t2_pc", 32'(pc), 32'h4);

    // jump and fetch in the same cycle: the request uses the jump target
    step(1'b1, 1'b1, 16'h0040, 1'b1);
    check_eq("t3_addr", 32'(mem_addr), 32'h0040);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("t3_pc", 32'(pc), 32'h0041);
    check_eq("t3_instr", 32'(instr), 32'(mem[16'h0040]));

    // slow memory; jump in the second REQ cycle aborts even with ack present
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    saved = instr;
    step(1'b0, 1'b1, 16'h1234, 1'b1);
    check_eq("t4_vld", 32'(instr_vld), 32'h0);
    check_eq("t4_instr", 32'(instr), 32'(saved));
    check_eq("t4_pc", 32'(pc), 32'h1234);
    check_eq("t4_idle", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("t4_novld", 32'(instr_vld), 32'h0);

    // PC wraps from FFFF to 0000
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("t5_instr", 32'(instr), 32'hBEEF);
    check_eq("t5_pc", 32'(pc), 32'h0000);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      fe_r = ($urandom % 4) != 0;
      j_r  = ($urandom % 12) == 0;
      ja_r = (($urandom % 4) == 0) ? 16'(16'hFFFE + ($urandom % 2)) : 16'($urandom);
      ae_r = ($urandom % 3) != 0;
      step(fe_r, j_r, ja_r, ae_r);
    end

`ifdef FETCH_TIMEOUT_EN
    // memory never answers: sticky error after TMO request cycles
    step(1'b0, 1'b1, 16'h0200, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int w = 0; w < TMO; w++) step(1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("tmo_err", 32'(err), 32'h1);
    check_eq("tmo_busy", 32'(busy), 32'h0);
    check_eq("tmo_pc", 32'(pc), 32'h0200);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("tmo_sticky", 32'(err), 32'h1);
`endif

    // asynchronous reset in the middle of a request
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    check_eq("mid_req", 32'(mem_rd), 32'h1);
    #2;
    rst_b = 1'b0;
    #1;
    check_eq("arst_mem_rd", 32'(mem_rd), 32'h0);
    check_eq("arst_err", 32'(err), 32'h0);
    check_eq("arst_pc", 32'(pc), 32'h0);
    fetch_en = 1'b0; jmp = 1'b0; ack_en = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_eq("post_rst_pc", 32'(pc), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
